// File: rtl/fab_pkg.sv
// Shared types and constants for the fab arithmetic engine.
package fab_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {WAIT, FIB, FACT, DONE} state_t;

    localparam logic [1:0] OP_INIT = 2'b00;
    localparam logic [1:0] OP_FIB  = 2'b01;
    localparam logic [1:0] OP_FACT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

endpackage

// File: rtl/fab_datapath.sv
// A/B/C register file with the adder, truncated multiplier and C decrementer.
// The load/step enables are mutually exclusive; load wins if ever overlapped.
module fab_datapath import fab_pkg::*; (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          fib_step,
    input  logic          fact_step,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] b,
    output logic          c_zero
);

    logic [DW-1:0]   a_q, b_q, c_q;
    logic [2*DW-1:0] prod;

    assign prod   = {{DW{1'b0}}, b_q} * {{DW{1'b0}}, c_q};
    assign b      = b_q;
    assign c_zero = (c_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (load) begin
            a_q <= '0;
            b_q <= DW'(1);
            c_q <= din;
        end else if (fib_step) begin
            a_q <= b_q;
            b_q <= a_q + b_q;
            c_q <= c_q - DW'(1);
        end else if (fact_step) begin
            b_q <= prod[DW-1:0];
            c_q <= c_q - DW'(1);
        end
    end

endmodule

// File: rtl/fab.sv
// Start/done handshaken FSM driving the fab datapath; out mirrors register B.
module fab import fab_pkg::*; (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [DW-1:0] in,
    input  logic [1:0]    op,
    output logic [DW-1:0] out,
    output logic          done
);

    state_t state;
    logic   c_zero;
    logic   load, fib_step, fact_step;

    // Enables are decoded from the current state so C is tested before each step.
    assign load      = (state == WAIT) && s && (op == OP_INIT);
    assign fib_step  = (state == FIB)  && !c_zero;
    assign fact_step = (state == FACT) && !c_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            done  <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (s) begin
                        case (op)
                            OP_FIB:  state <= FIB;
                            OP_FACT: state <= FACT;
                            default: begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                FIB, FACT: begin
                    if (c_zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!s) begin
                        state <= WAIT;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    fab_datapath u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .fib_step  (fib_step),
        .fact_step (fact_step),
        .din       (in),
        .b         (out),
        .c_zero    (c_zero)
    );

endmodule

// File: tb/tb_fab.sv
// Randomised and directed bench for fab against a transaction-level model.
module tb_fab;

    logic       clk = 1'b0;
    logic       reset, s, done;
    logic [7:0] in, out;
    logic [1:0] op;

    int checks = 0;
    int passed = 0;

    // model: whole-operation results, plus a countdown to when done must rise
    logic [7:0] m_a = 8'd0, m_b = 8'd0, m_c = 8'd0;
    int         phase = 0;   // 0 idle, 1 busy, 2 done
    int         cnt = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    fab dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .in    (in),
        .op    (op),
        .out   (out),
        .done  (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [7:0] t;
        if (reset) begin
            m_a = 8'd0; m_b = 8'd0; m_c = 8'd0;
            phase = 0;
            chk_en = 1'b1;
        end else begin
            case (phase)
                0: if (s) begin
                    case (op)
                        2'b00: begin m_a = 8'd0; m_b = 8'd1; m_c = in; phase = 2; end
                        2'b11: phase = 2;
                        2'b01: begin
                            for (int i = 0; i < int'(m_c); i++) begin
                                t = m_a + m_b; m_a = m_b; m_b = t;
                            end
                            cnt = int'(m_c) + 1; m_c = 8'd0; phase = 1;
                        end
                        default: begin
                            for (int i = int'(m_c); i > 0; i--) m_b = 8'(int'(m_b) * i);
                            cnt = int'(m_c) + 1; m_c = 8'd0; phase = 1;
                        end
                    endcase
                end
                1: begin
                    cnt--;
                    if (cnt == 0) phase = 2;
                end
                default: if (!s) phase = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // out is only pinned while not iterating; done is checked every cycle
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("done", int'(done), (phase == 2) ? 1 : 0);
            if (phase != 1) chk("out", int'(out), int'(m_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] d, input int hold, output int lat);
        s = 1'b1; op = o; in = d; lat = 0;
        do begin
            cyc();
            lat++;
            op = 2'($urandom); in = 8'($urandom);
        end while (!done && lat < 400);
        if (!done) chk("done_timeout", lat, -1);
        repeat (hold) cyc();
        s = 1'b0;
        cyc();
        chk("done_drop", int'(done), 0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; s = 1'b0; op = 2'b00; in = 8'd0;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (4) cyc();
        chk("reset_out", int'(out), 0);

        run_op(2'b00, 8'd4, 0, lat);  chk("init4_lat", lat, 1);
        chk("init4_out", int'(out), 1);
        run_op(2'b01, 8'd0, 2, lat);  chk("fib4_lat", lat, 6);
        chk("fib4_out", int'(out), 5);
        run_op(2'b00, 8'd3, 0, lat);
        run_op(2'b10, 8'd0, 0, lat);  chk("fact3_lat", lat, 5);
        chk("fact3_out", int'(out), 6);
        run_op(2'b00, 8'd6, 0, lat);
        run_op(2'b10, 8'd0, 0, lat);  chk("fact6_out", int'(out), 208);
        run_op(2'b10, 8'd0, 0, lat);  chk("fact_rpt_lat", lat, 2);
        chk("fact_rpt_out", int'(out), 208);
        run_op(2'b00, 8'd0, 0, lat);
        run_op(2'b01, 8'd0, 0, lat);  chk("fib0_lat", lat, 2);
        chk("fib0_out", int'(out), 1);
        run_op(2'b00, 8'd13, 0, lat);
        run_op(2'b01, 8'd0, 0, lat);  chk("fib13_out", int'(out), 121);

        run_op(2'b00, 8'd10, 0, lat);
        s = 1'b1; op = 2'b01;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; s = 1'b0;
        chk("midreset_out", int'(out), 0);
        chk("midreset_done", int'(done), 0);
        run_op(2'b11, 8'd77, 0, lat); chk("nop_lat", lat, 1);
        chk("nop_out", int'(out), 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end
            run_op(2'($urandom), 8'($urandom_range(0, 40)), int'($urandom_range(0, 3)), lat);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
